// File: rtl/det_pkg.sv
// Shared constants, types and the multiply schedule for the determinant sequencer.
package det_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int ROW_W  = DIM * ELEM_W;
  localparam int MAT_W  = DIM * ROW_W;
  localparam int STEPS3 = 9;
  localparam int STEPS2 = 2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  typedef enum logic [2:0] {LOAD_TMP, SUB_TMP, ADD_ACC, SUB_ACC, LOAD_ACC} op_t;

  // Element indices are row-major within the latched 3x3 window (a=0 .. i=8).
  typedef struct packed {
    op_t        op;
    logic [3:0] sel_x;
    logic       use_tmp;
    logic [3:0] sel_y;
  } step_t;

  function automatic step_t schedule(input logic is3, input logic [3:0] idx);
    step_t s;
    s = '{LOAD_TMP, 4'd0, 1'b0, 4'd0};
    if (is3) begin
      case (idx)
        4'd0: s = '{LOAD_TMP, 4'd4, 1'b0, 4'd8};
        4'd1: s = '{SUB_TMP,  4'd5, 1'b0, 4'd7};
        4'd2: s = '{ADD_ACC,  4'd0, 1'b1, 4'd0};
        4'd3: s = '{LOAD_TMP, 4'd3, 1'b0, 4'd8};
        4'd4: s = '{SUB_TMP,  4'd5, 1'b0, 4'd6};
        4'd5: s = '{SUB_ACC,  4'd1, 1'b1, 4'd0};
        4'd6: s = '{LOAD_TMP, 4'd3, 1'b0, 4'd7};
        4'd7: s = '{SUB_TMP,  4'd4, 1'b0, 4'd6};
        4'd8: s = '{ADD_ACC,  4'd2, 1'b1, 4'd0};
        default: ;
      endcase
    end else begin
      case (idx)
        4'd0: s = '{LOAD_ACC, 4'd0, 1'b0, 4'd4};
        4'd1: s = '{SUB_ACC,  4'd1, 1'b0, 4'd3};
        default: ;
      endcase
    end
    return s;
  endfunction

  // Positions outside the 5x5 bus read as zero so the window latch never slices past the bus.
  function automatic logic [ELEM_W-1:0] fetch(input logic [MAT_W-1:0] m,
                                               input logic [3:0] r,
                                               input logic [3:0] c);
    if (r >= 4'(DIM) || c >= 4'(DIM)) return '0;
    return m[int'(r) * ROW_W + int'(c) * ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/det_sequencer_if.sv
// Request/response bundle between the coprocessor control and the determinant sequencer.
interface det_sequencer_if;
  import det_pkg::*;

  logic              start;
  logic              size3;
  logic [2:0]        row_off;
  logic [2:0]        col_off;
  logic [MAT_W-1:0]  matrix_a;
  logic              busy;
  logic              done;
  logic              err;
  logic [ELEM_W-1:0] result;

  modport master (output start, size3, row_off, col_off, matrix_a,
                  input  busy, done, err, result);

  modport slave  (input  start, size3, row_off, col_off, matrix_a,
                  output busy, done, err, result);

endinterface

// File: rtl/det_mac_unit.sv
// Single 8x8 multiplier feeding a load/add/subtract into the acc or tmp register.
module det_mac_unit
  import det_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  op_t               op,
  input  logic [ELEM_W-1:0] x,
  input  logic [ELEM_W-1:0] y,
  output logic [ELEM_W-1:0] acc,
  output logic [ELEM_W-1:0] tmp
);

  logic [ELEM_W-1:0] prod;

  assign prod = x * y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      tmp <= '0;
    end else if (clr) begin
      acc <= '0;
      tmp <= '0;
    end else if (en) begin
      case (op)
        LOAD_TMP: tmp <= prod;
        SUB_TMP:  tmp <= tmp - prod;
        ADD_ACC:  acc <= acc + prod;
        SUB_ACC:  acc <= acc - prod;
        LOAD_ACC: acc <= prod;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/det_sequencer.sv
// Multi-cycle 2x2/3x3 determinant of a submatrix of the packed 5x5 bus, mod 2^ELEM_W,
// stepping one shared multiplier through a fixed schedule.
module det_sequencer
  import det_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  det_sequencer_if.slave bus
);

  state_t            state, next_state;
  logic [ELEM_W-1:0] elems [9];
  logic              is3;
  logic              bad;
  logic [3:0]        step;
  logic [3:0]        span;
  logic              range_bad;
  logic              last_step;
  logic              accept;
  logic              run_en;
  logic              finish;
  step_t             sched;
  logic [ELEM_W-1:0] op_x, op_y, acc, tmp;

  assign span      = bus.size3 ? 4'd3 : 4'd2;
  assign range_bad = (({1'b0, bus.row_off} + span) > 4'(DIM)) ||
                     (({1'b0, bus.col_off} + span) > 4'(DIM));
  assign last_step = (step == (is3 ? 4'(STEPS3 - 1) : 4'(STEPS2 - 1)));

  assign sched = schedule(is3, step);
  assign op_x  = elems[sched.sel_x];
  assign op_y  = sched.use_tmp ? tmp : elems[sched.sel_y];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = range_bad ? FIN : RUN;
      RUN:     if (last_step) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    run_en = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:    accept = bus.start;
      RUN:     run_en = 1'b1;
      FIN:     finish = 1'b1;
      default: ;
    endcase
  end

  // A rejected request skips RUN, so bad alone decides err and a zero result at FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) elems[k] <= '0;
      is3        <= 1'b0;
      bad        <= 1'b0;
      step       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        for (int k = 0; k < 9; k++)
          elems[k] <= fetch(bus.matrix_a, {1'b0, bus.row_off} + 4'(k / 3),
                            {1'b0, bus.col_off} + 4'(k % 3));
        is3      <= bus.size3;
        bad      <= range_bad;
        step     <= '0;
        bus.busy <= 1'b1;
        bus.err  <= 1'b0;
      end
      if (run_en) step <= step + 4'd1;
      if (finish) begin
        bus.result <= bad ? '0 : acc;
        bus.err    <= bad;
        bus.done   <= 1'b1;
        bus.busy   <= 1'b0;
      end
    end
  end

  det_mac_unit u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (run_en),
    .op  (sched.op),
    .x   (op_x),
    .y   (op_y),
    .acc (acc),
    .tmp (tmp)
  );

endmodule

// File: tb/tb_det_sequencer.sv
// Directed and randomized checks of det_sequencer against an integer cofactor-expansion model.
module tb_det_sequencer;
  import det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  det_sequencer_if bus ();

  det_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int k = 0; k < DIM * DIM; k++) m[k*ELEM_W +: ELEM_W] = 8'($urandom);
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] put(input logic [MAT_W-1:0] m, input int r,
                                           input int c, input int v);
    m[r*ROW_W + c*ELEM_W +: ELEM_W] = 8'(v);
    return m;
  endfunction

  function automatic bit out_of_range(input bit is3, input int r, input int c);
    int n;
    n = is3 ? 3 : 2;
    return (r + n > DIM) || (c + n > DIM);
  endfunction

  // Exact integer determinant by cofactor expansion, reduced mod 256 at the end.
  function automatic int ref_det(input logic [MAT_W-1:0] m, input bit is3,
                                 input int r, input int c);
    int a [3][3];
    int n;
    int d;
    n = is3 ? 3 : 2;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        a[i][j] = (i < n && j < n) ? int'(m[(r+i)*ROW_W + (c+j)*ELEM_W +: ELEM_W]) : 0;
    if (is3)
      d = a[0][0] * (a[1][1] * a[2][2] - a[1][2] * a[2][1])
        - a[0][1] * (a[1][0] * a[2][2] - a[1][2] * a[2][0])
        + a[0][2] * (a[1][0] * a[2][1] - a[1][1] * a[2][0]);
    else
      d = a[0][0] * a[1][1] - a[0][1] * a[1][0];
    return d & 255;
  endfunction

  // Entered at a falling edge; returns at the falling edge where done is seen (or the bound expires).
  task automatic applyStimulus(input bit is3, input logic [2:0] r, input logic [2:0] c,
                               input logic [MAT_W-1:0] m, input bit spam,
                               output int lat, output logic [7:0] res, output logic e);
    bit seen;
    seen        = 1'b0;
    lat         = 0;
    bus.start   = 1'b1;
    bus.size3   = is3;
    bus.row_off = r;
    bus.col_off = c;
    bus.matrix_a = m;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.matrix_a = rand_mat();
    @(negedge clk);
    checkOutput("busy_after_accept", bus.busy, 1);
    checkOutput("done_low_after_accept", bus.done, 0);
    checkOutput("err_cleared_on_accept", bus.err, 0);
    for (int k = 1; k <= 30 && !seen; k++) begin
      if (spam) begin
        bus.start    = 1'($urandom);
        bus.size3    = 1'($urandom);
        bus.row_off  = 3'($urandom);
        bus.col_off  = 3'($urandom);
        bus.matrix_a = rand_mat();
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        checkOutput("busy_while_running", bus.busy, 1);
      end
    end
    bus.start = 1'b0;
    checkOutput("done_within_bound", seen, 1);
    checkOutput("busy_low_with_done", bus.busy, 0);
    res = bus.result;
    e   = bus.err;
  endtask

  task automatic runCase(input string tag, input bit is3, input logic [2:0] r,
                         input logic [2:0] c, input logic [MAT_W-1:0] m, input bit spam,
                         input int exp_lat, input logic [7:0] exp_res, input logic exp_err);
    int         lat;
    logic [7:0] res;
    logic       e;
    applyStimulus(is3, r, c, m, spam, lat, res, e);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_result"}, res, exp_res);
    checkOutput({tag, "_err"}, e, exp_err);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput("done_idle_low", bus.done, 0);
    end
  endtask

  logic [MAT_W-1:0] mat_id, mat_ce, mat_22, mat_id22, m;
  bit               is3, spam, bad;
  logic [2:0]       r, c;

  initial begin
    bus.start    = 1'b0;
    bus.size3    = 1'b0;
    bus.row_off  = '0;
    bus.col_off  = '0;
    bus.matrix_a = '0;

    mat_id = '0;
    for (int i = 0; i < 3; i++) mat_id = put(mat_id, i, i, 1);

    mat_ce = '0;
    mat_ce = put(mat_ce, 0, 0, 6);  mat_ce = put(mat_ce, 0, 1, 1);   mat_ce = put(mat_ce, 0, 2, 1);
    mat_ce = put(mat_ce, 1, 0, 4);  mat_ce = put(mat_ce, 1, 1, 254); mat_ce = put(mat_ce, 1, 2, 5);
    mat_ce = put(mat_ce, 2, 0, 2);  mat_ce = put(mat_ce, 2, 1, 8);   mat_ce = put(mat_ce, 2, 2, 7);

    mat_22 = rand_mat();
    mat_22 = put(mat_22, 1, 3, 3);  mat_22 = put(mat_22, 1, 4, 8);
    mat_22 = put(mat_22, 2, 3, 4);  mat_22 = put(mat_22, 2, 4, 6);

    mat_id22 = '1;
    for (int i = 2; i < 5; i++)
      for (int j = 2; j < 5; j++)
        mat_id22 = put(mat_id22, i, j, (i == j) ? 1 : 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_err", bus.err, 0);
    checkOutput("reset_result", bus.result, 0);
    rst = 1'b0;
    idle(2);

    runCase("identity3", 1'b1, 3'd0, 3'd0, mat_id, 1'b0, 10, 8'h01, 1'b0);
    // Issued in the done cycle: exercises back-to-back acceptance.
    runCase("neg306", 1'b1, 3'd0, 3'd0, mat_ce, 1'b0, 10, 8'hCE, 1'b0);
    idle(2);
    runCase("two_by_two", 1'b0, 3'd1, 3'd3, mat_22, 1'b0, 3, 8'hF2, 1'b0);
    idle(1);
    runCase("identity_off22", 1'b1, 3'd2, 3'd2, mat_id22, 1'b0, 10, 8'h01, 1'b0);
    idle(1);
    runCase("range_row3", 1'b1, 3'd3, 3'd0, mat_id, 1'b0, 1, 8'h00, 1'b1);
    runCase("after_err", 1'b0, 3'd1, 3'd3, mat_22, 1'b0, 3, 8'hF2, 1'b0);
    idle(1);
    runCase("start_spam", 1'b1, 3'd0, 3'd0, mat_ce, 1'b1, 10, 8'hCE, 1'b0);
    idle(1);

    bus.start    = 1'b1;
    bus.size3    = 1'b1;
    bus.row_off  = 3'd0;
    bus.col_off  = 3'd0;
    bus.matrix_a = mat_ce;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_err", bus.err, 0);
    checkOutput("abort_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(15);
    runCase("after_abort", 1'b1, 3'd0, 3'd0, mat_ce, 1'b0, 10, 8'hCE, 1'b0);
    idle(1);

    for (int n = 0; n < 1000; n++) begin
      is3  = 1'($urandom);
      spam = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        r = 3'($urandom_range(0, 7));
        c = 3'($urandom_range(3, 7));
      end else if ($urandom_range(0, 3) == 0) begin
        r = 3'd0;
        c = 3'd0;
      end else begin
        r = 3'($urandom_range(0, is3 ? 2 : 3));
        c = 3'($urandom_range(0, is3 ? 2 : 3));
      end
      m   = rand_mat();
      bad = out_of_range(is3, int'(r), int'(c));
      runCase("random", is3, r, c, m, spam,
              bad ? 1 : (is3 ? 10 : 3),
              bad ? 8'h00 : 8'(ref_det(m, is3, int'(r), int'(c))),
              bad);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
